// File: rtl/qeciphy_tx_controller.sv
// Link-level TX bring-up controller: IDLE -> WAIT_LOCK -> TRAIN -> READY, with sticky FAULT.
// Optional TRAIN watchdog enabled by defining QECIPHY_TX_TRAIN_TIMEOUT_EN.
module qeciphy_tx_controller #(
  parameter int unsigned TRAIN_MIN_CYCLES     = 64,
  parameter int unsigned TRAIN_TIMEOUT_CYCLES = 65536
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic       tx_locked_i,
  input  logic       rx_rdy_i,
  input  logic       remote_rx_rdy_i,
  input  logic       fifo_ovf_i,
  input  logic       fifo_udf_i,
  output logic       tx_enable_o,
  output logic [1:0] tx_mode_o,
  output logic       tx_rdy_o,
  output logic       tx_fault_fatal_o,
  output logic [3:0] tx_error_code_o
);

  localparam logic [3:0] NO_ERROR            = 4'h0;
  localparam logic [3:0] TX_OVF_ERROR        = 4'h1;
  localparam logic [3:0] TX_UDF_ERROR        = 4'h2;
  localparam logic [3:0] TRAIN_TIMEOUT_ERROR = 4'h3;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_TRAIN = 2'b01;
  localparam logic [1:0] MODE_DATA  = 2'b10;

  localparam int unsigned   TC_W   = $clog2(TRAIN_MIN_CYCLES + 1);
  localparam logic [TC_W-1:0] TC_MAX = TC_W'(TRAIN_MIN_CYCLES);

  if (TRAIN_MIN_CYCLES < 1 || TRAIN_TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("qeciphy_tx_controller: TRAIN_MIN_CYCLES must be >=1 and TRAIN_TIMEOUT_CYCLES >=2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOCK, S_TRAIN, S_READY, S_FAULT
  } state_t;

  state_t          state, state_nxt;
  logic [TC_W-1:0] train_cnt, train_cnt_nxt, train_inc;
  logic [3:0]      err_nxt;
  logic            go_ready, to_hit;

`ifdef QECIPHY_TX_TRAIN_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TRAIN_TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;

  assign to_hit = (to_cnt == TO_W'(TRAIN_TIMEOUT_CYCLES - 1));

  // Counts only cycles spent in bring-up; READY and IDLE restart the watchdog.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                      to_cnt <= '0;
    else if (state_nxt == S_IDLE || state_nxt == S_READY) to_cnt <= '0;
    else if (state == S_WAIT_LOCK || state == S_TRAIN)   to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  // train_inc is the count including the current TRAIN cycle, so READY follows
  // exactly TRAIN_MIN_CYCLES cycles of training.
  always_comb begin
    train_inc = (train_cnt == TC_MAX) ? train_cnt : train_cnt + 1'b1;
    go_ready  = (train_inc == TC_MAX) && rx_rdy_i && remote_rx_rdy_i && tx_locked_i;
  end

  always_comb begin
    state_nxt     = state;
    train_cnt_nxt = train_cnt;
    err_nxt       = tx_error_code_o;
    if (!enable_i) begin
      state_nxt     = S_IDLE;
      train_cnt_nxt = '0;
      err_nxt       = NO_ERROR;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (to_hit) begin
            state_nxt = S_FAULT;
            err_nxt   = TRAIN_TIMEOUT_ERROR;
          end else if (tx_locked_i) begin
            state_nxt     = S_TRAIN;
            train_cnt_nxt = '0;
          end
        end
        S_TRAIN: begin
          train_cnt_nxt = train_inc;
          if (go_ready) begin
            state_nxt = S_READY;
          end else if (to_hit) begin
            state_nxt = S_FAULT;
            err_nxt   = TRAIN_TIMEOUT_ERROR;
          end else if (!tx_locked_i) begin
            state_nxt = S_WAIT_LOCK;
          end
        end
        S_READY: begin
          // FIFO errors outrank lock loss; overflow outranks underflow.
          if (fifo_ovf_i) begin
            state_nxt = S_FAULT;
            err_nxt   = TX_OVF_ERROR;
          end else if (fifo_udf_i) begin
            state_nxt = S_FAULT;
            err_nxt   = TX_UDF_ERROR;
          end else if (!tx_locked_i) begin
            state_nxt = S_WAIT_LOCK;
          end else if (!remote_rx_rdy_i || !rx_rdy_i) begin
            state_nxt     = S_TRAIN;
            train_cnt_nxt = '0;
          end
        end
        S_FAULT: state_nxt = S_FAULT;
        default: begin
          state_nxt     = S_IDLE;
          train_cnt_nxt = '0;
          err_nxt       = NO_ERROR;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change with the state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state            <= S_IDLE;
      train_cnt        <= '0;
      tx_enable_o      <= 1'b0;
      tx_mode_o        <= MODE_IDLE;
      tx_rdy_o         <= 1'b0;
      tx_fault_fatal_o <= 1'b0;
      tx_error_code_o  <= NO_ERROR;
    end else begin
      state            <= state_nxt;
      train_cnt        <= train_cnt_nxt;
      tx_enable_o      <= (state_nxt != S_IDLE);
      tx_mode_o        <= (state_nxt == S_TRAIN) ? MODE_TRAIN :
                          (state_nxt == S_READY) ? MODE_DATA  : MODE_IDLE;
      tx_rdy_o         <= (state_nxt == S_READY);
      tx_fault_fatal_o <= (state_nxt == S_FAULT);
      tx_error_code_o  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_qeciphy_tx_controller.sv
// Directed bench for qeciphy_tx_controller: bring-up, faults, retrain, lock loss, watchdog, reset.
module tb_qeciphy_tx_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, locked, rx_rdy, remote_rdy, ovf, udf;
  logic       tx_en;
  logic [1:0] mode;
  logic       rdy, fault;
  logic [3:0] code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qeciphy_tx_controller #(
    .TRAIN_MIN_CYCLES    (64),
    .TRAIN_TIMEOUT_CYCLES(200)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .enable_i        (enable),
    .tx_locked_i     (locked),
    .rx_rdy_i        (rx_rdy),
    .remote_rx_rdy_i (remote_rdy),
    .fifo_ovf_i      (ovf),
    .fifo_udf_i      (udf),
    .tx_enable_o     (tx_en),
    .tx_mode_o       (mode),
    .tx_rdy_o        (rdy),
    .tx_fault_fatal_o(fault),
    .tx_error_code_o (code)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts training-mode cycles until tx_rdy_o rises (bounded).
  task automatic train_count(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      if (mode == 2'b01) n++;
    end
  endtask

  int n;
  bit ok;
  bit changed;

  initial begin
    rst_n = 1'b0; enable = 1'b0; locked = 1'b0; rx_rdy = 1'b0;
    remote_rdy = 1'b0; ovf = 1'b0; udf = 1'b0;
    repeat (3) cyc();
    chk("rst_en",    8'(tx_en), 8'h0);
    chk("rst_mode",  8'(mode),  8'h0);
    chk("rst_rdy",   8'(rdy),   8'h0);
    chk("rst_fault", 8'(fault), 8'h0);
    chk("rst_code",  8'(code),  8'h0);
    rst_n = 1'b1;
    cyc();

    // 1: full bring-up
    enable = 1'b1; locked = 1'b1; rx_rdy = 1'b1; remote_rdy = 1'b1;
    cyc();
    chk("t1_en_1cyc", 8'(tx_en), 8'h1);
    chk("t1_waitlock_mode", 8'(mode), 8'h0);
    train_count(n, ok);
    chk("t1_ready", 8'(ok), 8'h1);
    chk("t1_train_cycles", 8'(n), 8'd64);
    chk("t1_mode_data", 8'(mode), 8'h2);

    // 2: simultaneous ovf+udf -> FAULT, ovf code, sticky
    ovf = 1'b1; udf = 1'b1;
    cyc();
    ovf = 1'b0; udf = 1'b0;
    chk("t2_rdy", 8'(rdy), 8'h0);
    chk("t2_fault", 8'(fault), 8'h1);
    chk("t2_code", 8'(code), 8'h1);
    changed = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (!fault || rdy || code != 4'h1 || !tx_en || mode != 2'b00) changed = 1'b1;
    end
    chk("t2_sticky", 8'(changed), 8'h0);

    // 3: enable drop clears the fault, then retrain
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    chk("t3_en", 8'(tx_en), 8'h0);
    chk("t3_fault", 8'(fault), 8'h0);
    chk("t3_code", 8'(code), 8'h0);
    chk("t3_mode", 8'(mode), 8'h0);
    train_count(n, ok);
    chk("t3_retrain", 8'(ok), 8'h1);

    // 4: remote not ready 3 cycles -> TRAIN with counter cleared
    remote_rdy = 1'b0;
    cyc();
    chk("t4_mode", 8'(mode), 8'h1);
    chk("t4_rdy", 8'(rdy), 8'h0);
    chk("t4_fault", 8'(fault), 8'h0);
    n = 1;
    cyc(); if (mode == 2'b01) n++;
    cyc(); if (mode == 2'b01) n++;
    remote_rdy = 1'b1;
    begin
      int m;
      train_count(m, ok);
      n += m;
    end
    chk("t4_ready", 8'(ok), 8'h1);
    chk("t4_train_cycles", 8'(n), 8'd64);

    // 5: lock loss in READY and in TRAIN; FIFO errors ignored in TRAIN
    locked = 1'b0;
    cyc();
    chk("t5_rdy_loss_mode", 8'(mode), 8'h0);
    chk("t5_rdy_loss_en", 8'(tx_en), 8'h1);
    chk("t5_rdy_loss_fault", 8'(fault), 8'h0);
    locked = 1'b1;
    cyc();
    chk("t5_relock_train", 8'(mode), 8'h1);
    ovf = 1'b1;
    cyc();
    ovf = 1'b0;
    chk("t5_train_ovf_ignored", 8'(fault), 8'h0);
    chk("t5_train_ovf_mode", 8'(mode), 8'h1);
    locked = 1'b0;
    cyc();
    chk("t5_train_loss_mode", 8'(mode), 8'h0);
    chk("t5_train_loss_en", 8'(tx_en), 8'h1);
    repeat (4) cyc();
    chk("t5_still_wait", 8'(mode), 8'h0);
    locked = 1'b1;
    train_count(n, ok);
    chk("t5_ready", 8'(ok), 8'h1);
    chk("t5_train_cycles", 8'(n), 8'd64);

    // underflow alone, coincident with lock loss: error wins
    udf = 1'b1; locked = 1'b0;
    cyc();
    udf = 1'b0; locked = 1'b1;
    chk("udf_fault", 8'(fault), 8'h1);
    chk("udf_code", 8'(code), 8'h2);
    chk("udf_rdy", 8'(rdy), 8'h0);

    // 6: training watchdog
    enable = 1'b0;
    cyc();
    enable = 1'b1; remote_rdy = 1'b0;
`ifdef QECIPHY_TX_TRAIN_TIMEOUT_EN
    repeat (200) cyc();
    chk("t6_no_early_fault", 8'(fault), 8'h0);
    cyc();
    chk("t6_timeout_fault", 8'(fault), 8'h1);
    chk("t6_timeout_code", 8'(code), 8'h3);
`else
    changed = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      cyc();
      if (fault || code != 4'h0) changed = 1'b1;
    end
    chk("t6_no_timeout", 8'(changed), 8'h0);
    chk("t6_still_train", 8'(mode), 8'h1);
`endif

    // async reset from READY, no glitch to READY on release
    enable = 1'b0;
    cyc();
    enable = 1'b1; remote_rdy = 1'b1;
    train_count(n, ok);
    chk("rst_pre_ready", 8'(ok), 8'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy", 8'(rdy), 8'h0);
    chk("arst_en", 8'(tx_en), 8'h0);
    chk("arst_mode", 8'(mode), 8'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("arst_rel_rdy", 8'(rdy), 8'h0);
    chk("arst_rel_en", 8'(tx_en), 8'h1);
    chk("arst_rel_mode", 8'(mode), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
